chirp_sweep: RTL and testbench

Parametrised next-generation chirp controller that drives the frequency control word and reset of the sinusoid NCO.
- Sweep modes: up, down, triangle.
- Burst count of chirps: finite or continuous.
- Inter-chirp gap set in clock cycles.
- Start/stop control, with configuration latched at start.
- Endpoint clamping, so the sweep never overshoots the programmed frequency limits.

---
 rtl/chirp_sweep.sv | 233 +++++++++++++++++++++++
 tb/tb_chirp_sweep.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/chirp_sweep.sv
// chirp_sweep -- chirp controller for a sinusoid NCO.
//
// Produces the NCO frequency control word and NCO reset for linear chirps.
// Supported sweeps are up, down and triangle (up, then down). A burst may be
// finite or continuous, and chirps may be separated by a gap counted in clock
// cycles. The configuration is latched when a burst starts. Each step is
// clamped so the word never passes the programmed limits and never wraps.
//
// Control contract: start and stop are level-sampled commands, with no
// valid/ready handshake. start is sampled only while idle; it is accepted
// (SWEEP next cycle) or rejected (cfg_err pulse next cycle). stop is sampled
// every cycle and wins over everything else. chirp_start, done and cfg_err are
// single-cycle pulses. All outputs are registered.
//
// The FSM state is held in the signal `state` (type state_t) for observation.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start, stop  burst start (idle only) / abort (any state)
//   mode         00 up, 01 down, 10 triangle, 11 treated as up
//   min_ctrl     lower frequency word
//   max_ctrl     upper frequency word
//   inc_rate     step size per update
//   div_rate     number of clocks between steps, minus one
//   delay        gap between chirps in cycles (0 = back-to-back)
//   n_chirps     chirps per burst (0 = continuous)
//   nco_ctrl     NCO frequency control word
//   nco_reset    NCO reset, high whenever not sweeping
//   chirp_start  pulse on the first cycle of each chirp
//   busy         high in SWEEP or GAP
//   done         pulse when a finite burst completes
//   cfg_err      pulse when a start is rejected
module chirp_sweep #(
    parameter int ACC_W   = 32,
    parameter int RATE_W  = 32,
    parameter int DELAY_W = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [ACC_W-1:0]   min_ctrl,
    input  logic [ACC_W-1:0]   max_ctrl,
    input  logic [ACC_W-1:0]   inc_rate,
    input  logic [RATE_W-1:0]  div_rate,
    input  logic [DELAY_W-1:0] delay,
    input  logic [CNT_W-1:0]   n_chirps,
    output logic [ACC_W-1:0]   nco_ctrl,
    output logic               nco_reset,
    output logic               chirp_start,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_TRI  = 2'b10;

    state_t              state;

    // Configuration captured when a burst starts
    logic [1:0]          mode_q;
    logic [ACC_W-1:0]    min_q;
    logic [ACC_W-1:0]    max_q;
    logic [ACC_W-1:0]    inc_q;
    logic [RATE_W-1:0]   div_q;
    logic [DELAY_W-1:0]  delay_q;
    logic [CNT_W-1:0]    n_q;

    logic [RATE_W-1:0]   rate_cnt;
    logic [CNT_W-1:0]    chirp_cnt;
    logic [DELAY_W-1:0]  gap_cnt;
    logic                dir_down;

    // Step helpers. Headroom is always measured toward the limit being
    // approached, so the compare never overflows and the word clamps exactly.
    logic [ACC_W-1:0]    up_room;
    logic [ACC_W-1:0]    dn_room;
    logic [ACC_W-1:0]    up_next;
    logic [ACC_W-1:0]    dn_next;
    logic                at_max;
    logic                at_min;
    logic                step;
    logic [CNT_W-1:0]    cnt_next;
    logic                last_chirp;
    logic [ACC_W-1:0]    start_word_q;
    logic                cfg_bad;
    logic                gap_last;

    always_comb begin
        up_room      = max_q - nco_ctrl;
        dn_room      = nco_ctrl - min_q;
        up_next      = (up_room < inc_q) ? max_q : nco_ctrl + inc_q;
        dn_next      = (dn_room < inc_q) ? min_q : nco_ctrl - inc_q;
        at_max       = (nco_ctrl == max_q);
        at_min       = (nco_ctrl == min_q);
        step         = (rate_cnt == div_q);
        cnt_next     = chirp_cnt + CNT_W'(1);
        last_chirp   = (n_q != '0) && (cnt_next == n_q);
        start_word_q = (mode_q == MODE_DOWN) ? max_q : min_q;
        cfg_bad      = (min_ctrl >= max_ctrl) || (inc_rate == '0);
        gap_last     = (gap_cnt == delay_q - DELAY_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_q      <= MODE_UP;
            min_q       <= '0;
            max_q       <= '0;
            inc_q       <= '0;
            div_q       <= '0;
            delay_q     <= '0;
            n_q         <= '0;
            rate_cnt    <= '0;
            chirp_cnt   <= '0;
            gap_cnt     <= '0;
            dir_down    <= 1'b0;
            nco_ctrl    <= '0;
            nco_reset   <= 1'b1;
            chirp_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            chirp_start <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;

            if (stop) begin
                state     <= IDLE;
                nco_ctrl  <= '0;
                nco_reset <= 1'b1;
                busy      <= 1'b0;
                rate_cnt  <= '0;
                chirp_cnt <= '0;
                gap_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (cfg_bad) begin
                                cfg_err <= 1'b1;
                            end else begin
                                // Mode 11 is folded into up here, so later logic sees only 00/01/10
                                mode_q      <= (mode == 2'b11) ? MODE_UP : mode;
                                min_q       <= min_ctrl;
                                max_q       <= max_ctrl;
                                inc_q       <= inc_rate;
                                div_q       <= div_rate;
                                delay_q     <= delay;
                                n_q         <= n_chirps;
                                nco_ctrl    <= (mode == MODE_DOWN) ? max_ctrl : min_ctrl;
                                dir_down    <= (mode == MODE_DOWN);
                                nco_reset   <= 1'b0;
                                chirp_start <= 1'b1;
                                busy        <= 1'b1;
                                rate_cnt    <= '0;
                                chirp_cnt   <= '0;
                                state       <= SWEEP;
                            end
                        end
                    end

                    SWEEP: begin
                        if (!step) begin
                            rate_cnt <= rate_cnt + RATE_W'(1);
                        end else begin
                            rate_cnt <= '0;
                            if (!dir_down && !at_max) begin
                                nco_ctrl <= up_next;
                            end else if (dir_down && !at_min) begin
                                nco_ctrl <= dn_next;
                            end else if (!dir_down && (mode_q == MODE_TRI)) begin
                                // Turn at the peak and take the first down step on
                                // the same update, so the peak is held only once.
                                dir_down <= 1'b1;
                                nco_ctrl <= dn_next;
                            end else begin
                                // Chirp complete. In continuous mode the counter wraps freely.
                                chirp_cnt <= cnt_next;
                                if (last_chirp) begin
                                    state     <= IDLE;
                                    done      <= 1'b1;
                                    nco_reset <= 1'b1;
                                    nco_ctrl  <= '0;
                                    busy      <= 1'b0;
                                end else if (delay_q == '0) begin
                                    nco_ctrl    <= start_word_q;
                                    dir_down    <= (mode_q == MODE_DOWN);
                                    chirp_start <= 1'b1;
                                end else begin
                                    state     <= GAP;
                                    nco_reset <= 1'b1;
                                    nco_ctrl  <= start_word_q;
                                    gap_cnt   <= '0;
                                end
                            end
                        end
                    end

                    GAP: begin
                        // The gap lasts exactly delay_q cycles with nco_reset high
                        if (gap_last) begin
                            state       <= SWEEP;
                            nco_reset   <= 1'b0;
                            chirp_start <= 1'b1;
                            rate_cnt    <= '0;
                            dir_down    <= (mode_q == MODE_DOWN);
                            nco_ctrl    <= start_word_q;
                        end else begin
                            gap_cnt <= gap_cnt + DELAY_W'(1);
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chirp_sweep.sv
// tb_chirp_sweep -- self-checking bench for chirp_sweep.
// Table of sweep vectors (configuration plus the expected word list of one
// chirp), expanded into per-cycle output records on an expected queue, then
// popped and compared each cycle. Hand-written sequences cover config errors,
// continuous mode with stop, start while busy, and asynchronous reset in GAP.
module tb_chirp_sweep;

    localparam int ACC_W   = 32;
    localparam int RATE_W  = 32;
    localparam int DELAY_W = 16;
    localparam int CNT_W   = 8;
    localparam int NV      = 7;
    localparam int RW      = ACC_W + 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [1:0]         mode = '0;
    logic [ACC_W-1:0]   min_ctrl = '0;
    logic [ACC_W-1:0]   max_ctrl = '0;
    logic [ACC_W-1:0]   inc_rate = '0;
    logic [RATE_W-1:0]  div_rate = '0;
    logic [DELAY_W-1:0] delay = '0;
    logic [CNT_W-1:0]   n_chirps = '0;
    logic [ACC_W-1:0]   nco_ctrl;
    logic               nco_reset;
    logic               chirp_start;
    logic               busy;
    logic               done;
    logic               cfg_err;

    chirp_sweep #(
        .ACC_W(ACC_W), .RATE_W(RATE_W), .DELAY_W(DELAY_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .min_ctrl(min_ctrl), .max_ctrl(max_ctrl), .inc_rate(inc_rate),
        .div_rate(div_rate), .delay(delay), .n_chirps(n_chirps),
        .nco_ctrl(nco_ctrl), .nco_reset(nco_reset), .chirp_start(chirp_start),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] inc;
        logic [31:0] div;
        logic [15:0] dly;
        logic [7:0]  n;
        logic [3:0]  cnt;
    } vec_t;

    vec_t        vecs   [NV];
    logic [31:0] vwords [NV][8];

    // ---------------- scoreboard ----------------
    // record layout: {cfg_err, nco_reset, chirp_start, busy, done, nco_ctrl}
    logic [RW-1:0] exp_q[$];
    int total = 0;
    int bad = 0;

    function automatic logic [RW-1:0] mk(input logic ce, input logic nr, input logic cs,
                                         input logic b, input logic d, input logic [31:0] w);
        return {ce, nr, cs, b, d, w};
    endfunction

    task automatic check(input string tag, input logic [RW-1:0] exp);
        logic [RW-1:0] act;
        act = {cfg_err, nco_reset, chirp_start, busy, done, nco_ctrl};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got ce=%0b nr=%0b cs=%0b busy=%0b done=%0b nco=%h, want ce=%0b nr=%0b cs=%0b busy=%0b done=%0b nco=%h",
                     tag, $time, act[RW-1], act[RW-2], act[RW-3], act[RW-4], act[RW-5], act[31:0],
                     exp[RW-1], exp[RW-2], exp[RW-3], exp[RW-4], exp[RW-5], exp[31:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_cfg(input logic [1:0] m, input logic [31:0] lo, input logic [31:0] hi,
                             input logic [31:0] inc, input logic [31:0] dv,
                             input logic [15:0] dl, input logic [7:0] n);
        mode = m; min_ctrl = lo; max_ctrl = hi; inc_rate = inc;
        div_rate = dv; delay = dl; n_chirps = n;
    endtask

    task automatic scramble_cfg();
        mode     = 2'($urandom_range(0, 3));
        min_ctrl = $urandom;
        max_ctrl = $urandom;
        inc_rate = $urandom;
        div_rate = $urandom_range(0, 5);
        delay    = 16'($urandom_range(0, 4));
        n_chirps = 8'($urandom_range(0, 3));
    endtask

    // Expand one table row into per-cycle expected records
    task automatic push_vec(input int k);
        vec_t v;
        v = vecs[k];
        for (int c = 0; c < int'(v.n); c++) begin
            for (int w = 0; w < int'(v.cnt); w++) begin
                for (int d = 0; d <= int'(v.div); d++) begin
                    exp_q.push_back(mk(1'b0, 1'b0, (w == 0 && d == 0), 1'b1, 1'b0, vwords[k][w]));
                end
            end
            if (c < int'(v.n) - 1) begin
                for (int g = 0; g < int'(v.dly); g++) begin
                    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, vwords[k][0]));
                end
            end
        end
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
    endtask

    task automatic run_vec(input int k);
        string tag;
        tag = $sformatf("vec%0d", k);
        push_vec(k);
        @(negedge clk);
        drive_cfg(vecs[k].mode, vecs[k].lo, vecs[k].hi, vecs[k].inc, vecs[k].div,
                  vecs[k].dly, vecs[k].n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (exp_q.size() > 0) begin
            check(tag, exp_q.pop_front());
            // Configuration changes while busy must not matter
            scramble_cfg();
            @(negedge clk);
        end
    endtask

    task automatic cfg_reject(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                              input logic [31:0] inc);
        @(negedge clk);
        drive_cfg(2'b00, lo, hi, inc, 32'd0, 16'd0, 8'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_pulse"}, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        @(negedge clk);
        check({tag, "_after"}, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0] = '{2'b00, 32'd100, 32'd130, 32'd10, 32'd1, 16'd0, 8'd1, 4'd4};
        vwords[0] = '{32'd100, 32'd110, 32'd120, 32'd130, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[1] = '{2'b01, 32'd100, 32'd125, 32'd10, 32'd0, 16'd0, 8'd1, 4'd4};
        vwords[1] = '{32'd125, 32'd115, 32'd105, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[2] = '{2'b00, 32'd100, 32'd125, 32'd10, 32'd0, 16'd0, 8'd1, 4'd4};
        vwords[2] = '{32'd100, 32'd110, 32'd120, 32'd125, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[3] = '{2'b10, 32'd100, 32'd130, 32'd10, 32'd0, 16'd3, 8'd2, 4'd7};
        vwords[3] = '{32'd100, 32'd110, 32'd120, 32'd130, 32'd120, 32'd110, 32'd100, 32'd0};
        vecs[4] = '{2'b00, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 32'd0, 16'd0, 8'd1, 4'd3};
        vwords[4] = '{32'hFFFF_FF00, 32'hFFFF_FF80, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[5] = '{2'b11, 32'd0, 32'd20, 32'd10, 32'd0, 16'd0, 8'd2, 4'd3};
        vwords[5] = '{32'd0, 32'd10, 32'd20, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[6] = '{2'b01, 32'd50, 32'd60, 32'd7, 32'd2, 16'd1, 8'd2, 4'd3};
        vwords[6] = '{32'd60, 32'd53, 32'd50, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));

        for (int k = 0; k < NV; k++) begin
            run_vec(k);
        end

        // Rejected starts
        cfg_reject("cfg_min_gt_max", 32'd200, 32'd100, 32'd10);
        cfg_reject("cfg_inc_zero", 32'd100, 32'd200, 32'd0);
        cfg_reject("cfg_min_eq_max", 32'd150, 32'd150, 32'd5);

        // Continuous mode: 0,10 chirps back-to-back past the counter wrap,
        // a stray start while busy, then stop mid-burst.
        @(negedge clk);
        drive_cfg(2'b00, 32'd0, 32'd10, 32'd10, 32'd0, 16'd0, 8'd0);
        for (int i = 0; i < 600; i++) begin
            exp_q.push_back(mk(1'b0, 1'b0, (i % 2) == 0, 1'b1, 1'b0, ((i % 2) == 1) ? 32'd10 : 32'd0));
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 600; i++) begin
            check("continuous", exp_q.pop_front());
            start = (i == 100);
            @(negedge clk);
        end
        start = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_idle", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        @(negedge clk);
        check("stop_no_done", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));

        // Asynchronous reset while in GAP
        drive_cfg(2'b10, 32'd100, 32'd130, 32'd10, 32'd0, 16'd5, 8'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("gap_entry", mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd100));
        repeat (8) @(negedge clk);
        check("in_gap", mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd100));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
